// File: rtl/itcm_arbiter.sv
// itcm_arbiter: shares the ITCM port between fetch and data/loader, data wins by default.
// Define ITCM_ARB_STARVE_EN to force a fetch grant after MAX_WAIT consecutive denials.
module itcm_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 1024,
    parameter int MAX_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          if_req,
    input  logic [DATA_WIDTH-1:0]         if_addr,
    output logic                          if_gnt,
    output logic                          if_rvalid,
    output logic [DATA_WIDTH-1:0]         if_rdata,
    output logic                          if_err,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [3:0]                    d_wstrb,
    input  logic [DATA_WIDTH-1:0]         d_addr,
    input  logic [DATA_WIDTH-1:0]         d_wdata,
    output logic                          d_gnt,
    output logic                          d_rvalid,
    output logic [DATA_WIDTH-1:0]         d_rdata,
    output logic                          d_err,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [3:0]                    mem_wstrb,
    output logic [$clog2(MEM_BYTES)-3:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);
    localparam int AW = $clog2(MEM_BYTES);

    logic d_inr, if_inr, force_if, unused_bits;
    logic rsp_valid, rsp_port, rsp_err, rsp_we;

    assign d_inr  = d_addr[DATA_WIDTH-1:AW] == '0;
    assign if_inr = if_addr[DATA_WIDTH-1:AW] == '0;

`ifdef ITCM_ARB_STARVE_EN
    localparam int CW = $clog2(MAX_WAIT + 1);
    logic [CW-1:0] wait_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wait_cnt <= '0;
        else wait_cnt <= (if_req && !if_gnt) ? wait_cnt + CW'(1) : '0;
    assign force_if    = wait_cnt == CW'(MAX_WAIT);
    assign unused_bits = ^{if_addr[1:0], d_addr[1:0]};
`else
    assign force_if    = 1'b0;
    assign unused_bits = ^{if_addr[1:0], d_addr[1:0], 1'(MAX_WAIT)};
`endif

    // Grants are masked during reset so nothing leaks out while rst_n is low
    assign d_gnt  = rst_n && d_req && !(force_if && if_req);
    assign if_gnt = rst_n && if_req && !d_gnt;

    assign mem_en    = (d_gnt && d_inr) || (if_gnt && if_inr);
    assign mem_we    = d_gnt && d_inr && d_we;
    assign mem_wstrb = mem_we ? d_wstrb : '0;
    assign mem_wdata = d_gnt ? d_wdata : '0;
    assign mem_addr  = d_gnt ? d_addr[AW-1:2] : if_gnt ? if_addr[AW-1:2] : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_port  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_we    <= 1'b0;
        end else begin
            rsp_valid <= d_gnt || if_gnt;
            rsp_port  <= d_gnt;
            rsp_err   <= d_gnt ? !d_inr : !if_inr;
            rsp_we    <= d_gnt && d_we;
        end

    assign if_rvalid = rsp_valid && !rsp_port;
    assign if_err    = if_rvalid && rsp_err;
    assign if_rdata  = (if_rvalid && !rsp_err) ? mem_rdata : '0;
    assign d_rvalid  = rsp_valid && rsp_port;
    assign d_err     = d_rvalid && rsp_err;
    assign d_rdata   = (d_rvalid && !rsp_err && !rsp_we) ? mem_rdata : '0;
endmodule

// File: tb/tb_itcm_arbiter.sv
// tb_itcm_arbiter: directed vector table plus contention, starvation and reset sequences.
module tb_itcm_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        if_req = 1'b0, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr = '0, if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0, d_gnt, d_rvalid, d_err;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wstrb;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata = '0;
    logic [31:0] mem [256];
    int checks = 0, errors = 0;

    typedef struct {
        logic ir; logic [31:0] ia; logic dr; logic dw; logic [3:0] ds; logic [31:0] da; logic [31:0] dd;
        logic eig; logic edg; logic een; logic [7:0] ema; logic ewe; logic [3:0] ews;
        logic eiv; logic [31:0] eird; logic eie; logic edv; logic [31:0] edrd; logic ede;
    } vec_t;
    vec_t v[14];

    itcm_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model, preloaded while reset is held
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[0]   <= 32'h0000_1697;
            mem[1]   <= 32'h0000_0013;
            mem[4]   <= 32'h1110_0513;
            mem[255] <= 32'hDEAD_BEEF;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " if_gnt"}, 32'(if_gnt), 0);
        chk({tag, " d_gnt"}, 32'(d_gnt), 0);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_wstrb"}, 32'(mem_wstrb), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
        chk({tag, " if_rvalid"}, 32'(if_rvalid), 0);
        chk({tag, " if_rdata"}, if_rdata, 0);
        chk({tag, " if_err"}, 32'(if_err), 0);
        chk({tag, " d_rvalid"}, 32'(d_rvalid), 0);
        chk({tag, " d_rdata"}, d_rdata, 0);
        chk({tag, " d_err"}, 32'(d_err), 0);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_wstrb = ds; d_addr = da; d_wdata = dd;
    endtask

    initial begin
        //        ir ia        dr dw ds   da        dd            eig edg een ema    ewe ews   eiv eird          eie edv edrd          ede
        v[0]  = '{0, 32'h000, 0, 0, 4'h0, 32'h000, 32'h0,        0,  0,  0,  8'h00, 0,  4'h0, 0,  32'h0,        0,  0,  32'h0,        0};
        v[1]  = '{1, 32'h000, 0, 0, 4'h0, 32'h000, 32'h0,        1,  0,  1,  8'h00, 0,  4'h0, 0,  32'h0,        0,  0,  32'h0,        0};
        v[2]  = '{0, 32'h000, 0, 0, 4'h0, 32'h000, 32'h0,        0,  0,  0,  8'h00, 0,  4'h0, 1,  32'h00001697, 0,  0,  32'h0,        0};
        v[3]  = '{0, 32'h000, 1, 1, 4'h2, 32'h010, 32'hAABBCCDD, 0,  1,  1,  8'h04, 1,  4'h2, 0,  32'h0,        0,  0,  32'h0,        0};
        v[4]  = '{1, 32'h010, 0, 0, 4'h0, 32'h000, 32'h0,        1,  0,  1,  8'h04, 0,  4'h0, 0,  32'h0,        0,  1,  32'h0,        0};
        v[5]  = '{1, 32'h004, 1, 0, 4'h0, 32'h000, 32'h0,        0,  1,  1,  8'h00, 0,  4'h0, 1,  32'h1110CC13, 0,  0,  32'h0,        0};
        v[6]  = '{1, 32'h004, 0, 0, 4'h0, 32'h000, 32'h0,        1,  0,  1,  8'h01, 0,  4'h0, 0,  32'h0,        0,  1,  32'h00001697, 0};
        v[7]  = '{0, 32'h000, 1, 0, 4'h0, 32'h400, 32'h0,        0,  1,  0,  8'h00, 0,  4'h0, 1,  32'h00000013, 0,  0,  32'h0,        0};
        v[8]  = '{0, 32'h000, 1, 1, 4'hF, 32'h404, 32'hFFFFFFFF, 0,  1,  0,  8'h00, 0,  4'h0, 0,  32'h0,        0,  1,  32'h0,        1};
        v[9]  = '{1, 32'hFFC, 0, 0, 4'h0, 32'h000, 32'h0,        1,  0,  0,  8'h00, 0,  4'h0, 0,  32'h0,        0,  1,  32'h0,        1};
        v[10] = '{1, 32'h3FC, 0, 0, 4'h0, 32'h000, 32'h0,        1,  0,  1,  8'hFF, 0,  4'h0, 1,  32'h0,        1,  0,  32'h0,        0};
        v[11] = '{0, 32'h000, 1, 0, 4'h0, 32'h004, 32'h0,        0,  1,  1,  8'h01, 0,  4'h0, 1,  32'hDEADBEEF, 0,  0,  32'h0,        0};
        v[12] = '{0, 32'h000, 0, 0, 4'h0, 32'h000, 32'h0,        0,  0,  0,  8'h00, 0,  4'h0, 0,  32'h0,        0,  1,  32'h00000013, 0};
        v[13] = '{0, 32'h000, 0, 0, 4'h0, 32'h000, 32'h0,        0,  0,  0,  8'h00, 0,  4'h0, 0,  32'h0,        0,  0,  32'h0,        0};

        // Requests held during reset must not be granted
        drive(1, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1 chk_zero("reset");
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(v[i].ir, v[i].ia, v[i].dr, v[i].dw, v[i].ds, v[i].da, v[i].dd);
            #1;
            chk($sformatf("v%0d if_gnt", i), 32'(if_gnt), 32'(v[i].eig));
            chk($sformatf("v%0d d_gnt", i), 32'(d_gnt), 32'(v[i].edg));
            chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(v[i].een));
            if (v[i].een) begin
                chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(v[i].ema));
                chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v[i].ewe));
            end
            if (v[i].ewe) chk($sformatf("v%0d mem_wstrb", i), 32'(mem_wstrb), 32'(v[i].ews));
            chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(v[i].eiv));
            chk($sformatf("v%0d if_rdata", i), if_rdata, v[i].eird);
            chk($sformatf("v%0d if_err", i), 32'(if_err), 32'(v[i].eie));
            chk($sformatf("v%0d d_rvalid", i), 32'(d_rvalid), 32'(v[i].edv));
            chk($sformatf("v%0d d_rdata", i), d_rdata, v[i].edrd);
            chk($sformatf("v%0d d_err", i), 32'(d_err), 32'(v[i].ede));
        end

        // Both ports held high for a long stretch
        @(negedge clk);
        drive(1, 32'h0, 1, 0, 4'h0, 32'h4, 32'h0);
`ifdef ITCM_ARB_STARVE_EN
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk($sformatf("starve c%0d if_gnt", c), 32'(if_gnt), 32'(c == 5));
            chk($sformatf("starve c%0d d_gnt", c), 32'(d_gnt), 32'(c != 5));
            @(negedge clk);
        end
`else
        for (int c = 1; c <= 8; c++) begin
            #1;
            chk($sformatf("prio c%0d if_gnt", c), 32'(if_gnt), 0);
            chk($sformatf("prio c%0d d_gnt", c), 32'(d_gnt), 1);
            @(negedge clk);
        end
`endif
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);

        // Reset lands right after a data grant; its response must vanish
        drive(0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);
        #1 chk("midrst d_gnt", 32'(d_gnt), 1);
        @(posedge clk);
        rst_n = 1'b0;
        if_req = 1'b1;
        #1 chk_zero("midrst a");
        @(negedge clk);
        #1 chk_zero("midrst b");
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("post c%0d d_rvalid", c), 32'(d_rvalid), 0);
            chk($sformatf("post c%0d if_rvalid", c), 32'(if_rvalid), 0);
            @(negedge clk);
        end

        // Arbiter still works after recovering from reset
        drive(0, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0);
        #1 chk("recover d_gnt", 32'(d_gnt), 1);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("recover d_rvalid", 32'(d_rvalid), 1);
        chk("recover d_rdata", d_rdata, 32'h0000_1697);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/itcm_arbiter.md
# itcm_arbiter

Two-port arbiter and sequencer in front of the 1 KB instruction TCM. It shares the single memory port between the instruction-fetch requester and a data/loader requester; the loader uses it for program download and constant reads. It issues one word access per cycle to a synchronous-read memory and returns each response one cycle later, tagged to the port that won. It sits between the fetch/LSU units and the ITCM macro, and supplies an out-of-range error that the bare memory lacks.

## Interface
- `DATA_WIDTH`, 32, data and address width of both requester ports.
- `MEM_BYTES`, 1024, ITCM size in bytes; power of two, multiple of 4.
- `MAX_WAIT`, 4, consecutive fetch denials before fetch is forced (starvation guard only).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  DATA_WIDTH  fetch byte address; bits [1:0] are ignored.
- `if_gnt`  out  1  fetch accepted this cycle (combinational).
- `if_rvalid`  out  1  fetch response valid.
- `if_rdata`  out  DATA_WIDTH  fetch read word.
- `if_err`  out  1  fetch response is out of range.
- `d_req`  in  1  data/loader request.
- `d_we`  in  1  1 = write, 0 = read.
- `d_wstrb`  in  4  byte strobes for a write; bit i covers byte lane i (little-endian).
- `d_addr`  in  DATA_WIDTH  data byte address; bits [1:0] are ignored.
- `d_wdata`  in  DATA_WIDTH  write word.
- `d_gnt`  out  1  data request accepted this cycle (combinational).
- `d_rvalid`  out  1  data response valid; also pulses for writes.
- `d_rdata`  out  DATA_WIDTH  data read word; 0 for writes.
- `d_err`  out  1  data response is out of range.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write.
- `mem_wstrb`  out  4  memory byte enables.
- `mem_addr`  out  log2(MEM_BYTES)-2  word address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid on the cycle after `mem_en`.

## Operation
- **Handshake:** a requester holds `req` and its payload stable until it sees `gnt`. At most one `gnt` is high per cycle. A grant is given in the same cycle as the request when the port wins.
- **Arbitration:** fixed priority, data port over fetch.
- **In-range grant:**
  - `mem_en`=1.
  - `mem_addr`=`addr[log2(MEM_BYTES)-1:2]`.
  - `mem_we`/`mem_wstrb`/`mem_wdata` are driven from the data port. Fetch always reads, with `mem_wstrb`=0.
- **Out-of-range grant** (`addr >= MEM_BYTES`): the grant is still given, `mem_en`=0, and the response returns with `err`=1 and `rdata`=0. A write to an out-of-range address is dropped.
- **Response tracking:** a registered response tracker holds `{valid, port, err, we}`. The granted port's `rvalid` is asserted on the next cycle.
  - `rdata` is taken from `mem_rdata` for an in-range read, and is 0 otherwise.
- **Back-to-back:** a new grant is allowed every cycle. A response and a new grant can occur in the same cycle; the responses are independent.
- **Port isolation:** responses are never routed to the non-granted port.

## Timing
- Grant is combinational from `req` and the arbiter state. Response latency is exactly 1 cycle after the grant, for reads and writes alike.
- **Reset:** all outputs are 0, the tracker is cleared and the starvation counter is 0. `if_gnt`/`d_gnt` are 0 while `rst_n`=0.
- **Reset mid-operation:** a response in flight is discarded, and no `rvalid` appears after reset is released.
- **Simultaneous requests:** only one port is granted. The loser keeps its request asserted and is served on a later cycle.
- **Idle:** with no request, `mem_en`=0 and no response follows.

## Configuration
- `ITCM_ARB_STARVE_EN` defined: a counter increments each cycle that `if_req`=1 and `if_gnt`=0, and clears when fetch is granted or `if_req`=0.
  - When the counter equals `MAX_WAIT`, fetch wins over data for that one cycle.
  - Worst-case fetch wait is therefore `MAX_WAIT` cycles.
- Undefined: pure fixed priority. Fetch can starve indefinitely under continuous `d_req`, and no counter is built.

## Test plan
- **Fetch read:** preload word 0x00001697 at addr 0; `if_req` with `if_addr`=0 -> `if_gnt` same cycle; next cycle `if_rvalid`=1, `if_rdata`=0x00001697, `if_err`=0.
- **Byte write then read:** data write `d_addr`=0x10, `d_wstrb`=4'b0010, `d_wdata`=0xAABBCCDD over stored 0x11100513 -> `d_rvalid` next cycle; a fetch of 0x10 returns 0x1110CC13.
- **Contention:** `if_req`=`d_req`=1 -> `d_gnt`=1, `if_gnt`=0; fetch is granted on the first cycle `d_req` drops, and each response lands on its own port.
- **Starvation (macro defined, MAX_WAIT=4):** hold `d_req` and `if_req` high -> `if_gnt` rises on the 5th cycle, then the data port resumes winning.
- **Out of range:** `d_req` read at 0x400 -> `mem_en`=0; next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0.
- **Reset mid-flight:** assert `rst_n`=0 on the cycle after a grant -> no `rvalid` appears, and all outputs are 0 until after release.
